// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: datapath handshake and control bundle between controller and datapath
interface multicycle_controller_if;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        PCWrite;
    logic        PCSource;
    logic        IRWrite;
    logic        IorD;
    logic        MemRead;
    logic        MemWrite;
    logic        RegWrite;
    logic        MemtoReg;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [3:0]  aluctrl;
    modport master (
        input  instr, zero, mem_ready,
        output PCWrite, PCSource, IRWrite, IorD, MemRead, MemWrite,
               RegWrite, MemtoReg, ALUSrcA, ALUSrcB, aluctrl
    );
    modport slave (
        output instr, zero, mem_ready,
        input  PCWrite, PCSource, IRWrite, IorD, MemRead, MemWrite,
               RegWrite, MemtoReg, ALUSrcA, ALUSrcB, aluctrl
    );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: multi-cycle RV32 sequencing FSM; MCC_RETIRE_CNT_EN adds the retired counter
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    multicycle_controller_if.master     bus,
    output logic [3:0]                  state,
    output logic                        illegal
`ifdef MCC_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0]            retired
`endif
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
        MEMWR = 4'd5, EXEC = 4'd6, RWB = 4'd7, BRANCH = 4'd8, TRAP = 4'd9
    } state_t;
    typedef struct packed {
        logic       pc_write;
        logic       pc_source;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu;
    } ctl_t;
    localparam logic [6:0] OP_R = 7'b0110011, OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011, OP_BEQ = 7'b1100011;
    state_t     st, nxt;
    ctl_t       c;
    logic [6:0] op;
    logic [3:0] fn;
    logic       fn_ok;
    logic       unused_instr;
    assign op = bus.instr[6:0];
    assign fn = {bus.instr[30], bus.instr[14:12]};
    assign fn_ok = fn inside {4'b0000, 4'b1000, 4'b0111, 4'b0110};
    assign unused_instr = &{1'b0, bus.instr[31], bus.instr[29:15], bus.instr[11:7]};
    assign state = st;
    always_comb begin
        nxt = st;
        case (st)
            FETCH:   nxt = bus.mem_ready ? DECODE : FETCH;
            DECODE:  nxt = op == OP_R ? EXEC : (op == OP_LW || op == OP_SW) ? MEMADR :
                           op == OP_BEQ ? BRANCH : TRAP;
            EXEC:    nxt = fn_ok ? RWB : TRAP;
            RWB:     nxt = FETCH;
            MEMADR:  nxt = op == OP_LW ? MEMRD : op == OP_SW ? MEMWR : TRAP;
            MEMRD:   nxt = bus.mem_ready ? MEMWB : MEMRD;
            MEMWB:   nxt = FETCH;
            MEMWR:   nxt = bus.mem_ready ? FETCH : MEMWR;
            BRANCH:  nxt = FETCH;
            TRAP:    nxt = TRAP;
            default: nxt = TRAP;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= FETCH;
            illegal <= 1'b0;
        end else begin
            st <= nxt;
            if (nxt == TRAP) illegal <= 1'b1;
        end
    end
    // Strobes decode from the registered state; only PCWrite/IRWrite look at mem_ready or zero
    always_comb begin
        c     = '0;
        c.alu = 4'b0010;
        case (st)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
                c.ir_write  = bus.mem_ready;
                c.pc_write  = bus.mem_ready;
            end
            DECODE: c.alu_src_b = 2'b11;
            EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu = fn == 4'b1000 ? 4'b0110 : fn == 4'b0111 ? 4'b0000 :
                        fn == 4'b0110 ? 4'b0001 : 4'b0010;
            end
            RWB: c.reg_write = 1'b1;
            MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu       = 4'b0110;
                c.pc_source = 1'b1;
                c.pc_write  = bus.zero;
            end
            default: c.alu = 4'b0010;
        endcase
    end
    // Holding reset silences every strobe, even though the state register already reads FETCH
    assign {bus.PCWrite, bus.PCSource, bus.IRWrite, bus.IorD, bus.MemRead, bus.MemWrite,
            bus.RegWrite, bus.MemtoReg, bus.ALUSrcA, bus.ALUSrcB, bus.aluctrl} = rst_n ? c : '0;
`ifdef MCC_RETIRE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) retired <= '0;
        else if (st == RWB || st == MEMWB || st == BRANCH || (st == MEMWR && bus.mem_ready))
            retired <= retired + CNT_W'(1);
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: table-driven per-cycle checks of state, strobes, illegal and retired count
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] state;
    logic illegal;
    logic [14:0] ctl;
    int checks = 0;
    int failures = 0;
`ifdef MCC_RETIRE_CNT_EN
    logic [3:0] retired;
    logic [3:0] exp_cnt = '0;
`endif
    multicycle_controller_if bus ();
    multicycle_controller #(.CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .state(state), .illegal(illegal)
`ifdef MCC_RETIRE_CNT_EN
        , .retired(retired)
`endif
    );
    always #5 clk = ~clk;
    assign ctl = {bus.PCWrite, bus.PCSource, bus.IRWrite, bus.IorD, bus.MemRead, bus.MemWrite,
                  bus.RegWrite, bus.MemtoReg, bus.ALUSrcA, bus.ALUSrcB, bus.aluctrl};
    // field order: PCWrite PCSource IRWrite IorD MemRead MemWrite RegWrite MemtoReg ALUSrcA ALUSrcB aluctrl
    localparam logic [14:0] C_RST  = 15'b0_0_0_0_0_0_0_0_0_00_0000;
    localparam logic [14:0] C_FR   = 15'b1_0_1_0_1_0_0_0_0_01_0010;
    localparam logic [14:0] C_FW   = 15'b0_0_0_0_1_0_0_0_0_01_0010;
    localparam logic [14:0] C_DEC  = 15'b0_0_0_0_0_0_0_0_0_11_0010;
    localparam logic [14:0] C_ADD  = 15'b0_0_0_0_0_0_0_0_1_00_0010;
    localparam logic [14:0] C_SUB  = 15'b0_0_0_0_0_0_0_0_1_00_0110;
    localparam logic [14:0] C_AND  = 15'b0_0_0_0_0_0_0_0_1_00_0000;
    localparam logic [14:0] C_OR   = 15'b0_0_0_0_0_0_0_0_1_00_0001;
    localparam logic [14:0] C_RWB  = 15'b0_0_0_0_0_0_1_0_0_00_0010;
    localparam logic [14:0] C_MA   = 15'b0_0_0_0_0_0_0_0_1_10_0010;
    localparam logic [14:0] C_MRD  = 15'b0_0_0_1_1_0_0_0_0_00_0010;
    localparam logic [14:0] C_MWB  = 15'b0_0_0_0_0_0_1_1_0_00_0010;
    localparam logic [14:0] C_MWR  = 15'b0_0_0_1_0_1_0_0_0_00_0010;
    localparam logic [14:0] C_BR1  = 15'b1_1_0_0_0_0_0_0_1_00_0110;
    localparam logic [14:0] C_BR0  = 15'b0_1_0_0_0_0_0_0_1_00_0110;
    localparam logic [14:0] C_TRAP = 15'b0_0_0_0_0_0_0_0_0_00_0010;
    localparam logic [31:0] I_ADD = 32'h002081B3, I_SUB = 32'h402081B3, I_AND = 32'h0020F1B3;
    localparam logic [31:0] I_OR = 32'h0020E1B3, I_LW = 32'h0000A183, I_SW = 32'h0030A023;
    localparam logic [31:0] I_BEQ = 32'h00208463, I_BAD = 32'h002091B3, I_7F = 32'h0000007F;
    typedef struct {
        logic        r;
        logic [31:0] i;
        logic        z;
        logic        m;
        logic [3:0]  s;
        logic [14:0] c;
        logic        il;
        string       tag;
    } vec_t;
    typedef struct {
        logic [3:0]  s;
        logic [14:0] c;
        logic        il;
        string       tag;
    } exp_t;
    vec_t tbl[$];
    exp_t sb[$];
    function automatic void v(input logic r, input logic [31:0] i, input logic z, input logic m,
                              input logic [3:0] s, input logic [14:0] c, input string tag);
        tbl.push_back('{r, i, z, m, s, c, 1'b0, tag});
    endfunction
    task automatic cmp(input string tag, input string what, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s %s: got %0h want %0h", tag, what, got, want);
        end
    endtask
    task automatic step(input logic r, input logic [31:0] i, input logic z, input logic m,
                        input logic [3:0] s, input logic [14:0] c, input logic il, input string tag);
        exp_t e;
        @(negedge clk);
        rst_n = r;
        bus.instr = i;
        bus.zero = z;
        bus.mem_ready = m;
        sb.push_back('{s, c, il, tag});
        #1;
        e = sb.pop_front();
        cmp(e.tag, "state", 32'(state), 32'(e.s));
        cmp(e.tag, "ctl", 32'(ctl), 32'(e.c));
        cmp(e.tag, "illegal", 32'(illegal), 32'(e.il));
`ifdef MCC_RETIRE_CNT_EN
        if (!r) exp_cnt = '0;
        cmp(e.tag, "retired", 32'(retired), 32'(exp_cnt));
        if (r && (s == 4'd7 || s == 4'd4 || s == 4'd8 || (s == 4'd5 && m))) exp_cnt = exp_cnt + 4'd1;
`endif
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end
    initial begin
        rst_n = 1'b1;
        bus.instr = '0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        #1 rst_n = 1'b0;
        v(0, I_ADD, 0, 1, 0, C_RST, "reset");
        v(1, I_ADD, 0, 1, 0, C_FR, "add_f"); v(1, I_ADD, 0, 1, 1, C_DEC, "add_d");
        v(1, I_ADD, 0, 1, 6, C_ADD, "add_x"); v(1, I_ADD, 0, 1, 7, C_RWB, "add_wb");
        v(1, I_SUB, 0, 0, 0, C_FW, "sub_fwait"); v(1, I_SUB, 0, 1, 0, C_FR, "sub_f");
        v(1, I_SUB, 0, 0, 1, C_DEC, "sub_d_ign"); v(1, I_SUB, 0, 1, 6, C_SUB, "sub_x");
        v(1, I_SUB, 0, 1, 7, C_RWB, "sub_wb");
        v(1, I_AND, 0, 1, 0, C_FR, "and_f"); v(1, I_AND, 0, 1, 1, C_DEC, "and_d");
        v(1, I_AND, 0, 1, 6, C_AND, "and_x"); v(1, I_AND, 0, 1, 7, C_RWB, "and_wb");
        v(1, I_OR, 0, 1, 0, C_FR, "or_f"); v(1, I_OR, 0, 1, 1, C_DEC, "or_d");
        v(1, I_OR, 0, 1, 6, C_OR, "or_x"); v(1, I_OR, 0, 1, 7, C_RWB, "or_wb");
        v(1, I_LW, 0, 1, 0, C_FR, "lw_f"); v(1, I_LW, 0, 1, 1, C_DEC, "lw_d");
        v(1, I_LW, 0, 1, 2, C_MA, "lw_a"); v(1, I_LW, 0, 0, 3, C_MRD, "lw_rd0");
        v(1, I_LW, 0, 0, 3, C_MRD, "lw_rd1"); v(1, I_LW, 0, 1, 3, C_MRD, "lw_rd2");
        v(1, I_LW, 0, 1, 4, C_MWB, "lw_wb");
        v(1, I_SW, 0, 1, 0, C_FR, "sw_f"); v(1, I_SW, 0, 1, 1, C_DEC, "sw_d");
        v(1, I_SW, 0, 1, 2, C_MA, "sw_a"); v(1, I_SW, 0, 0, 5, C_MWR, "sw_wr0");
        v(1, I_SW, 0, 1, 5, C_MWR, "sw_wr1");
        v(1, I_BEQ, 1, 1, 0, C_FR, "beq1_f"); v(1, I_BEQ, 1, 1, 1, C_DEC, "beq1_d");
        v(1, I_BEQ, 1, 1, 8, C_BR1, "beq1_br");
        v(1, I_BEQ, 0, 1, 0, C_FR, "beq0_f"); v(1, I_BEQ, 0, 1, 1, C_DEC, "beq0_d");
        v(1, I_BEQ, 0, 1, 8, C_BR0, "beq0_br");
        v(1, I_SW, 0, 1, 0, C_FR, "rsw_f"); v(1, I_SW, 0, 1, 1, C_DEC, "rsw_d");
        v(1, I_SW, 0, 1, 2, C_MA, "rsw_a"); v(1, I_SW, 0, 0, 5, C_MWR, "rsw_wr");
        v(0, I_SW, 0, 0, 0, C_RST, "rsw_rst"); v(1, I_SW, 0, 0, 0, C_FW, "rsw_after");
        foreach (tbl[k])
            step(tbl[k].r, tbl[k].i, tbl[k].z, tbl[k].m, tbl[k].s, tbl[k].c, tbl[k].il, tbl[k].tag);
        step(1, I_BAD, 0, 1, 0, C_FR, 0, "bad_f");
        step(1, I_BAD, 0, 1, 1, C_DEC, 0, "bad_d");
        step(1, I_BAD, 0, 1, 6, C_ADD, 0, "bad_x");
        for (int t = 0; t < 10; t++) step(1, I_ADD, 1, t[0], 9, C_TRAP, 1, "bad_trap");
        step(0, I_7F, 0, 1, 0, C_RST, 0, "op7f_rst");
        step(1, I_7F, 0, 1, 0, C_FR, 0, "op7f_f");
        step(1, I_7F, 0, 1, 1, C_DEC, 0, "op7f_d");
        for (int t = 0; t < 3; t++) step(1, I_LW, 0, 1, 9, C_TRAP, 1, "op7f_trap");
        step(0, I_BEQ, 1, 1, 0, C_RST, 0, "beq17_rst");
        for (int n = 0; n < 17; n++) begin
            step(1, I_BEQ, 1, 1, 0, C_FR, 0, "beq17_f");
            step(1, I_BEQ, 1, 1, 1, C_DEC, 0, "beq17_d");
            step(1, I_BEQ, 1, 1, 8, C_BR1, 0, "beq17_br");
        end
        step(1, I_BEQ, 1, 0, 0, C_FW, 0, "beq17_end");
`ifdef MCC_RETIRE_CNT_EN
        cmp("beq17_wrap", "retired", 32'(retired), 32'd1);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
